// File: rtl/ysyx_25030081_rf_pkg.sv
// Shared constants for the NPC integer register file with pending-write scoreboard.
package ysyx_25030081_rf_pkg;

    localparam int unsigned RF_ADDR_WIDTH_DEF = 32'd5;
    localparam int unsigned DATA_WIDTH_DEF    = 32'd32;
    localparam int unsigned NR_READ_DEF       = 32'd2;
    localparam int unsigned NR_READ_MAX       = 32'd4;
    localparam int unsigned CNT_WIDTH_DEF     = 32'd2;
    localparam int unsigned X0_IDX            = 32'd0;
    localparam int unsigned A0_IDX            = 32'd10;
    localparam int unsigned CNT_SAT_DEF       = (32'd1 << CNT_WIDTH_DEF) - 32'd1;

    function automatic int unsigned cnt_sat(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/ysyx_25030081_rf_sb_cnt.sv
// One register's pending-write counter: saturating up/down with flush clear.
module ysyx_25030081_rf_sb_cnt
    import ysyx_25030081_rf_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic nonzero,
    output logic full,
    output logic one
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_r;

    // Outstanding-write count; simultaneous inc and dec cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (inc && !dec && !full) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else if (dec && !inc && nonzero) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign nonzero = (cnt_r != CNT_ZERO);
    assign full    = &cnt_r;
    assign one     = (cnt_r == CNT_ONE);

endmodule

// File: rtl/ysyx_25030081_rf_sb.sv
// Multi-port integer register file with writeback bypass and a per-register
// pending-write scoreboard used by issue to detect RAW hazards.
module ysyx_25030081_rf_sb
    import ysyx_25030081_rf_pkg::*;
#(
    parameter int unsigned RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned NR_READ       = NR_READ_DEF,
    parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NR_READ*RF_ADDR_WIDTH-1:0]  raddr,
    output logic [NR_READ*DATA_WIDTH-1:0]     rdata,
    output logic [NR_READ-1:0]                rbusy,
    input  logic                              alloc_valid,
    input  logic [RF_ADDR_WIDTH-1:0]          alloc_addr,
    output logic                              alloc_ready,
    input  logic                              wb_valid,
    input  logic [RF_ADDR_WIDTH-1:0]          wb_addr,
    input  logic [DATA_WIDTH-1:0]             wb_data,
    input  logic                              flush,
    output logic [(1<<RF_ADDR_WIDTH)-1:0]     busy_vec,
    output logic [DATA_WIDTH-1:0]             a0
);

    localparam int unsigned NREG = 32'd1 << RF_ADDR_WIDTH;
    localparam logic [RF_ADDR_WIDTH-1:0] X0_ADDR = RF_ADDR_WIDTH'(X0_IDX);

    logic [DATA_WIDTH-1:0] regs_r [NREG];
    logic [NREG-1:0]       nonzero_s;
    logic [NREG-1:0]       full_s;
    logic [NREG-1:0]       one_s;
    logic [NREG-1:1]       inc_s;
    logic [NREG-1:1]       dec_s;
    logic                  alloc_fire_s;

    // A saturated destination may still be claimed if writeback retires one this cycle
    always_comb begin
        alloc_ready = 1'b1;
        if ((alloc_addr != X0_ADDR) && full_s[alloc_addr] &&
            !(wb_valid && (wb_addr == alloc_addr))) begin
            alloc_ready = 1'b0;
        end else begin
            alloc_ready = 1'b1;
        end
    end

    assign alloc_fire_s = alloc_valid && alloc_ready;

    // Architectural storage; x0 slot is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wb_valid && (wb_addr != X0_ADDR)) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    assign nonzero_s[0] = 1'b0;
    assign full_s[0]    = 1'b0;
    assign one_s[0]     = 1'b0;

    for (genvar r = 1; r < int'(NREG); r++) begin : g_cnt
        localparam logic [RF_ADDR_WIDTH-1:0] R_ADDR = RF_ADDR_WIDTH'(r);

        assign inc_s[r] = alloc_fire_s && (alloc_addr == R_ADDR);
        assign dec_s[r] = wb_valid && (wb_addr == R_ADDR);

        ysyx_25030081_rf_sb_cnt #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc_s[r]),
            .dec     (dec_s[r]),
            .clr     (flush),
            .nonzero (nonzero_s[r]),
            .full    (full_s[r]),
            .one     (one_s[r])
        );
    end

    for (genvar p = 0; p < int'(NR_READ); p++) begin : g_rd
        logic [RF_ADDR_WIDTH-1:0] ra_s;
        logic [DATA_WIDTH-1:0]    rd_s;
        logic                     rb_s;
        logic                     hit_s;

        assign ra_s  = raddr[p*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
        assign hit_s = wb_valid && (wb_addr == ra_s);

        // Read mux: x0 first, then same-cycle writeback, then storage
        always_comb begin
            rd_s = {DATA_WIDTH{1'b0}};
            if (ra_s == X0_ADDR) begin
                rd_s = {DATA_WIDTH{1'b0}};
            end else if (hit_s) begin
                rd_s = wb_data;
            end else begin
                rd_s = regs_r[ra_s];
            end
        end

        // The last outstanding write landing this cycle satisfies the reader
        assign rb_s = (ra_s != X0_ADDR) && nonzero_s[ra_s] && !(hit_s && one_s[ra_s]);

        assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = rd_s;
        assign rbusy[p]                          = rb_s;
    end

    assign busy_vec = nonzero_s;
    assign a0       = regs_r[A0_IDX];

endmodule

// File: tb/tb_ysyx_25030081_rf_sb.sv
// Scoreboard bench for ysyx_25030081_rf_sb: expectations queued at drive time,
// drained and compared on the falling edge.
module tb_ysyx_25030081_rf_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic        alloc_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic [31:0] busy_vec;
    logic [31:0] a0;

    ysyx_25030081_rf_sb dut (
        .clk         (clk),
        .rst         (rst),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .busy_vec    (busy_vec),
        .a0          (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mregs [32];
    int          mcnt  [32];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: return rdata[31:0];
            1: return rdata[63:32];
            2: return {31'd0, rbusy[0]};
            3: return {31'd0, rbusy[1]};
            4: return {31'd0, alloc_ready};
            5: return busy_vec;
            6: return a0;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_valid && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a);
        return (a != 5'd0) && (mcnt[a] != 0) && !(wb_valid && wb_addr == a && mcnt[a] == 1);
    endfunction

    function automatic logic m_ready();
        return !((alloc_addr != 5'd0) && (mcnt[alloc_addr] == 3) && !(wb_valid && wb_addr == alloc_addr));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'd0;
            mcnt[i]  = 0;
        end
    endtask

    task automatic expect_const(input string tag, input int sel, input logic [31:0] exp);
        sb_q.push_back('{tag, sel, exp});
    endtask

    task automatic push_model();
        logic [31:0] bv;
        bv = 32'd0;
        for (int i = 1; i < 32; i++) bv[i] = (mcnt[i] != 0);
        sb_q.push_back('{"rdata0", 0, m_rdata(raddr[4:0])});
        sb_q.push_back('{"rdata1", 1, m_rdata(raddr[9:5])});
        sb_q.push_back('{"rbusy0", 2, {31'd0, m_rbusy(raddr[4:0])}});
        sb_q.push_back('{"rbusy1", 3, {31'd0, m_rbusy(raddr[9:5])}});
        sb_q.push_back('{"alloc_ready", 4, {31'd0, m_ready()}});
        sb_q.push_back('{"busy_vec", 5, bv});
        sb_q.push_back('{"a0", 6, mregs[10]});
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic model_step();
        logic fire;
        fire = alloc_valid && m_ready();
        for (int r = 1; r < 32; r++) begin
            logic inc;
            logic dec;
            inc = fire && (alloc_addr == r[4:0]);
            dec = wb_valid && (wb_addr == r[4:0]);
            if (flush) mcnt[r] = 0;
            else if (inc && !dec && mcnt[r] < 3) mcnt[r] = mcnt[r] + 1;
            else if (dec && !inc && mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
        end
        if (wb_valid && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
    endtask

    // One clock: queue expectations, compare on negedge, then advance the model
    task automatic cycle();
        push_model();
        @(negedge clk);
        drain();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_addr = 5'd0;
        wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        flush = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0_addr, input logic [4:0] a1_addr);
        raddr = {a1_addr, a0_addr};
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
    endtask

    task automatic alloc(input logic [4:0] a);
        alloc_valid = 1'b1; alloc_addr = a;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd(5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state on every register through both ports
        for (int i = 0; i < 32; i++) begin
            rd(i[4:0], 5'(31 - i));
            expect_const("rst_rd0", 0, 32'd0);
            expect_const("rst_ready", 4, 32'd1);
            cycle();
        end

        // write + bypass, then storage, then x0 ignored
        wb(5'd5, 32'hDEAD_BEEF); rd(5'd5, 5'd0);
        expect_const("bypass_x5", 0, 32'hDEAD_BEEF);
        cycle();
        idle();
        expect_const("stored_x5", 0, 32'hDEAD_BEEF);
        cycle();
        wb(5'd0, 32'h0000_1234); rd(5'd0, 5'd0);
        expect_const("x0_bypass", 0, 32'd0);
        cycle();
        idle();
        expect_const("x0_stored", 1, 32'd0);
        cycle();

        // saturate x7
        rd(5'd0, 5'd7);
        repeat (3) begin alloc(5'd7); cycle(); end
        expect_const("x7_full_ready", 4, 32'd0);
        expect_const("x7_busy_vec", 5, 32'h0000_0080);
        cycle();
        wb(5'd7, 32'h0000_0011);
        expect_const("x7_full_wb_ready", 4, 32'd1);
        cycle();
        wb_valid = 1'b0;
        expect_const("x7_still_full", 4, 32'd0);
        cycle();
        idle();
        wb(5'd7, 32'h0000_0022); cycle();           // 3 -> 2
        wb(5'd7, 32'h0000_0055);
        expect_const("x7_cnt2_rbusy", 3, 32'd1);
        cycle();                                     // 2 -> 1
        wb(5'd7, 32'h0000_0055);
        expect_const("x7_cnt1_rbusy", 3, 32'd0);
        expect_const("x7_cnt1_rdata", 1, 32'h0000_0055);
        cycle();
        idle();
        expect_const("x7_clear", 5, 32'd0);
        cycle();

        // x9 alloc/wb collisions and wb without outstanding write
        rd(5'd9, 5'd0);
        alloc(5'd9); cycle();
        alloc(5'd9); wb(5'd9, 32'h0000_0099); cycle();
        idle();
        expect_const("x9_hold", 5, 32'h0000_0200);
        cycle();
        wb(5'd9, 32'h0000_0001); cycle();
        wb(5'd9, 32'h0000_0077); cycle();
        idle();
        expect_const("x9_nounder_data", 0, 32'h0000_0077);
        expect_const("x9_nounder_busy", 5, 32'd0);
        cycle();

        // flush overrides counters but keeps writeback data
        alloc(5'd3); cycle();
        alloc(5'd4); cycle();
        alloc(5'd4); flush = 1'b1; wb(5'd3, 32'h0000_000A); rd(5'd3, 5'd4);
        cycle();
        idle();
        expect_const("flush_busy", 5, 32'd0);
        expect_const("flush_x3", 0, 32'h0000_000A);
        cycle();

        // random traffic with a small address range to hit saturation and a0
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 3) != 0) alloc(5'($urandom_range(0, 11)));
            if ($urandom_range(0, 2) == 0) wb(5'($urandom_range(0, 11)), $urandom());
            flush = ($urandom_range(0, 40) == 0);
            rd(5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)));
            cycle();
        end

        // asynchronous reset between edges
        idle();
        alloc(5'd10); cycle();
        wb(5'd10, 32'h0BAD_F00D); cycle();
        idle();
        rd(5'd10, 5'd5);
        expect_const("pre_rst_a0", 6, 32'h0BAD_F00D);
        cycle();
        alloc(5'd6); cycle();
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        expect_const("async_rst_busy", 5, 32'd0);
        expect_const("async_rst_a0", 6, 32'd0);
        expect_const("async_rst_x5", 1, 32'd0);
        push_model();
        drain();
        #1;
        rst = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
